// File: rtl/arm_multicycle_ctrl.sv
// arm_multicycle_ctrl: multicycle ARM control FSM with NZCV flags and condition-gated writes.
module arm_multicycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ImmSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUControl,
    output logic [1:0]  ResultSrc,
    output logic        Mov,
    output logic [3:0]  State
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;
    state_t     r_state, w_next;
    logic [3:0] r_flags;
    logic [3:0] w_cond, w_cmd, w_rd, w_unused;
    logic [1:0] w_op, w_alu_ctl;
    logic       w_i, w_s, w_is_cmp, w_cond_ex, w_exec;
    logic       w_n, w_z, w_c, w_v;
    assign w_cond   = Instr[19:16];
    assign w_op     = Instr[15:14];
    assign w_i      = Instr[13];
    assign w_cmd    = Instr[12:9];
    assign w_s      = Instr[8];
    assign w_rd     = Instr[3:0];
    assign w_unused = Instr[7:4];
    assign {w_n, w_z, w_c, w_v} = r_flags;
    assign w_is_cmp = w_cmd == 4'b1010;
    assign w_exec   = r_state == EXECR || r_state == EXECI;
    assign w_alu_ctl = (w_cmd == 4'b0010 || w_is_cmp) ? 2'b01 :
                       (w_cmd == 4'b0000)             ? 2'b10 :
                       (w_cmd == 4'b1100)             ? 2'b11 : 2'b00;
    assign Mov    = w_op == 2'b00 && w_cmd == 4'b1101;
    assign RegSrc = {w_op == 2'b01 && !w_s, w_op == 2'b10};
    assign ImmSrc = w_op;
    assign State  = r_state;
    always_comb begin
        case (w_cond)
            4'b0000: w_cond_ex = w_z;
            4'b0001: w_cond_ex = !w_z;
            4'b0010: w_cond_ex = w_c;
            4'b0011: w_cond_ex = !w_c;
            4'b0100: w_cond_ex = w_n;
            4'b0101: w_cond_ex = !w_n;
            4'b0110: w_cond_ex = w_v;
            4'b0111: w_cond_ex = !w_v;
            4'b1000: w_cond_ex = w_c && !w_z;
            4'b1001: w_cond_ex = !w_c || w_z;
            4'b1010: w_cond_ex = w_n == w_v;
            4'b1011: w_cond_ex = w_n != w_v;
            4'b1100: w_cond_ex = !w_z && (w_n == w_v);
            4'b1101: w_cond_ex = w_z || (w_n != w_v);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= FETCH;
            r_flags <= 4'b0000;
        end else begin
            r_state <= w_next;
            if (w_exec && w_cond_ex && (w_s || w_is_cmp))
                r_flags <= ALUFlags;
        end
    end
    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:   w_next = DECODE;
            DECODE:  w_next = w_op == 2'b01 ? MEMADR :
                              w_op == 2'b10 ? BRANCH :
                              w_op == 2'b11 ? FETCH  :
                              w_i           ? EXECI  : EXECR;
            MEMADR:  w_next = w_s ? MEMREAD : MEMWRITE;
            MEMREAD: w_next = MEMWB;
            EXECR:   w_next = ALUWB;
            EXECI:   w_next = ALUWB;
            default: w_next = FETCH;
        endcase
    end
    // Enables are gated by CondEx in the writeback states; reset overrides all of them.
    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 2'b00;
        ResultSrc  = 2'b00;
        case (r_state)
            FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR:  ALUSrcB = 2'b01;
            MEMREAD: AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = w_cond_ex;
                PCWrite   = w_cond_ex && w_rd == 4'd15;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = w_cond_ex;
            end
            EXECR: ALUControl = w_alu_ctl;
            EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = w_alu_ctl;
            end
            ALUWB: begin
                RegWrite = w_cond_ex && !w_is_cmp;
                PCWrite  = w_cond_ex && !w_is_cmp && w_rd == 4'd15;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = w_cond_ex;
            end
            default: ;
        endcase
        if (!reset) begin
            PCWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            IRWrite  = 1'b0;
        end
    end
endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// tb_arm_multicycle_ctrl: directed and random instructions checked against an
// instruction-level model of sequence length, enables and flag tracking.
module tb_arm_multicycle_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [19:0] Instr = '0;
    logic [3:0]  ALUFlags = '0;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, Mov;
    logic [1:0]  RegSrc, ImmSrc, ALUSrcB, ALUControl, ResultSrc;
    logic [3:0]  State;
    int          n_pass = 0;
    int          n_total = 0;
    logic [3:0]  m_flags = 4'b0000;

    always #5 clk = ~clk;

    arm_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .RegSrc(RegSrc), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ResultSrc(ResultSrc),
        .Mov(Mov), .State(State)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Architectural condition: even codes test a predicate, odd codes invert it.
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n = f[3], z = f[2], cy = f[1], v = f[0];
        bit base;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = n == v;
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic logic [1:0] alu_code(input logic [3:0] cmd);
        return (cmd == 4'b0010 || cmd == 4'b1010) ? 2'b01 :
               (cmd == 4'b0000) ? 2'b10 : (cmd == 4'b1100) ? 2'b11 : 2'b00;
    endfunction

    task automatic run_instr(input logic [31:0] word, input bit force_af,
                             input logic [3:0] af, input int rst_at);
        logic [3:0] cnd = word[31:28];
        logic [1:0] op = word[27:26];
        bit imm = word[25];
        logic [3:0] cmd = word[24:21];
        bit sl = word[20];
        logic [3:0] rd = word[15:12];
        bit is_dp = op == 2'b00;
        bit is_mem = op == 2'b01;
        bit is_br = op == 2'b10;
        bit is_cmp = is_dp && cmd == 4'b1010;
        bit wb_reg = (is_mem && sl) || (is_dp && !is_cmp);
        int len = is_dp ? 4 : is_mem ? (sl ? 5 : 4) : is_br ? 3 : 2;
        logic [3:0] seq [5];
        bit ce, last;
        seq[0] = 4'd0;
        seq[1] = 4'd1;
        seq[2] = is_mem ? 4'd2 : is_br ? 4'd9 : imm ? 4'd7 : 4'd6;
        seq[3] = is_mem ? (sl ? 4'd3 : 4'd5) : 4'd8;
        seq[4] = 4'd4;
        Instr = word[31:12];
        for (int k = 0; k < len; k++) begin
            ALUFlags = force_af ? af : 4'($urandom);
            #3;
            ce = cond_ok(cnd, m_flags);
            last = k == len - 1;
            if (k == rst_at) begin
                reset = 1'b0;
                #1;
                chk("rst_state_hold", State, seq[k]);
                chk("rst_pcwrite", PCWrite, 0);
                chk("rst_irwrite", IRWrite, 0);
                chk("rst_regwrite", RegWrite, 0);
                chk("rst_memwrite", MemWrite, 0);
                @(posedge clk);
                #1;
                chk("rst_state_fetch", State, 0);
                chk("rst_pcwrite_fetch", PCWrite, 0);
                chk("rst_irwrite_fetch", IRWrite, 0);
                m_flags = 4'b0000;
                reset = 1'b1;
                return;
            end
            chk($sformatf("State[%0d] %h", k, word), State, seq[k]);
            chk($sformatf("IRWrite[%0d]", k), IRWrite, k == 0);
            chk($sformatf("PCWrite[%0d] %h", k, word), PCWrite,
                k == 0 || (last && ce && (is_br || (wb_reg && rd == 4'd15))));
            chk($sformatf("RegWrite[%0d] %h", k, word), RegWrite, last && ce && wb_reg);
            chk($sformatf("MemWrite[%0d] %h", k, word), MemWrite, last && ce && is_mem && !sl);
            chk($sformatf("AdrSrc[%0d]", k), AdrSrc, is_mem && k == 3);
            chk($sformatf("ALUSrcA[%0d]", k), ALUSrcA, k < 2);
            chk($sformatf("ALUSrcB[%0d]", k), ALUSrcB,
                k < 2 ? 2 : (k == 2 && (is_mem || is_br || (is_dp && imm))) ? 1 : 0);
            chk($sformatf("ResultSrc[%0d]", k), ResultSrc,
                (k < 2 || (is_br && k == 2)) ? 2 : (is_mem && sl && k == 4) ? 1 : 0);
            chk($sformatf("ALUControl[%0d] %h", k, word), ALUControl,
                (is_dp && k == 2) ? alu_code(cmd) : 2'b00);
            chk($sformatf("Mov[%0d]", k), Mov, is_dp && cmd == 4'b1101);
            chk($sformatf("RegSrc[%0d]", k), RegSrc, {is_mem && !sl, is_br});
            chk($sformatf("ImmSrc[%0d]", k), ImmSrc, op);
            @(posedge clk);
            if (is_dp && k == 2 && ce && (sl || is_cmp)) m_flags = ALUFlags;
            #1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] cmds [7] = '{4'b0100, 4'b0010, 4'b1010, 4'b0000, 4'b1100, 4'b1101, 4'b0111};
        logic [31:0] w;
        repeat (2) @(posedge clk);
        #1;
        chk("init_state", State, 0);
        chk("init_pcwrite", PCWrite, 0);
        chk("init_irwrite", IRWrite, 0);
        reset = 1'b1;
        run_instr(32'hE0821003, 1, 4'b1111, -1);
        run_instr(32'hE2500001, 1, 4'b0100, -1);
        run_instr(32'h0A000002, 0, 4'b0000, -1);
        run_instr(32'hE1500001, 1, 4'b0000, -1);
        run_instr(32'h0A000002, 0, 4'b0000, -1);
        run_instr(32'hE5902004, 0, 4'b0000, -1);
        run_instr(32'hE5802008, 0, 4'b0000, -1);
        run_instr(32'h03A01005, 0, 4'b0000, -1);
        run_instr(32'hEC000000, 0, 4'b0000, -1);
        run_instr(32'hE082F003, 0, 4'b0000, -1);
        run_instr(32'hE592F004, 0, 4'b0000, -1);
        run_instr(32'hE1500001, 1, 4'b0100, -1);
        run_instr(32'h03A01005, 0, 4'b0000, -1);
        run_instr(32'hE5902004, 0, 4'b0000, 3);
        run_instr(32'h0A000002, 0, 4'b0000, -1);
        for (int i = 0; i < 300; i++) begin
            w = $urandom;
            w[24:21] = cmds[$urandom_range(0, 6)];
            run_instr(w, 0, 4'b0000, -1);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
